ssd_scan_controller: RTL and testbench

Parametrised time-multiplexed seven-segment display scanner: generates the refresh timebase internally and cycles through NUM_DIGITS digits. Each frame it takes a coherent snapshot of all digit values, decodes them (hex or BCD mode), and drives common anode/cathode enables and segment lines. It adds leading-zero blanking, per-digit decimal points, PWM brightness and anti-ghosting dead time. It sits between the numeric datapath (counters, converters) and the board's SSD pins, and supersedes the bare digit-select mux.

---
 rtl/ssd_pkg.sv | 36 +++
 rtl/ssd_glyph_decoder.sv | 36 +++
 rtl/ssd_scan_controller.sv | 142 ++++++++++++++
 tb/tb_ssd_scan_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared glyph constants and helpers for the seven-segment scan controller.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_A    = 7'h77;
  localparam logic [6:0] SEG_B    = 7'h7C;
  localparam logic [6:0] SEG_C    = 7'h39;
  localparam logic [6:0] SEG_D    = 7'h5E;
  localparam logic [6:0] SEG_E    = 7'h79;
  localparam logic [6:0] SEG_F    = 7'h71;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Converts an active-high level into the pin level for the board polarity.
  function automatic logic drive_level(input logic active, input logic act_low);
    return active ^ act_low;
  endfunction

endpackage

// File: rtl/ssd_glyph_decoder.sv
// Combinational 4-bit value to seven-segment glyph; BCD mode shows a dash for 10-15.
module ssd_glyph_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic       i_mode_bcd,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = SEG_OFF;
    if (i_mode_bcd && (i_value > 4'd9)) begin
      o_glyph = SEG_DASH;
    end else begin
      case (i_value)
        4'h0: o_glyph = SEG_0;
        4'h1: o_glyph = SEG_1;
        4'h2: o_glyph = SEG_2;
        4'h3: o_glyph = SEG_3;
        4'h4: o_glyph = SEG_4;
        4'h5: o_glyph = SEG_5;
        4'h6: o_glyph = SEG_6;
        4'h7: o_glyph = SEG_7;
        4'h8: o_glyph = SEG_8;
        4'h9: o_glyph = SEG_9;
        4'hA: o_glyph = SEG_A;
        4'hB: o_glyph = SEG_B;
        4'hC: o_glyph = SEG_C;
        4'hD: o_glyph = SEG_D;
        4'hE: o_glyph = SEG_E;
        4'hF: o_glyph = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed seven-segment scanner with per-frame snapshot, leading-zero
// blanking, PWM brightness and one-cycle dead time at every slot start.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_BITS = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          mode_bcd,
  input  logic                          blank_lz,
  input  logic [BRIGHT_BITS-1:0]        brightness,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [clog2(NUM_DIGITS)-1:0]  digit_sel,
  output logic                          frame_tick
);

  localparam int               SEL_W    = clog2(NUM_DIGITS);
  localparam int               PRE_W    = clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic             AL       = 1'(ACTIVE_LOW != 0);

  logic [PRE_W-1:0]        r_presc;
  logic [SEL_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic                    r_sh_bcd;
  logic                    r_sh_blz;

  logic                    w_snap;
  logic [4*NUM_DIGITS-1:0] w_digits;
  logic [NUM_DIGITS-1:0]   w_dp_req;
  logic                    w_bcd;
  logic                    w_blz;
  logic [NUM_DIGITS-1:0]   w_blank_mask;
  logic                    w_run_zero;
  logic [3:0]              w_value;
  logic [6:0]              w_glyph;
  logic                    w_blank;
  logic [BRIGHT_BITS-1:0]  w_pwm;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_seg;
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   w_an_pin;
  logic [6:0]              w_seg_pin;
  logic                    w_dp_pin;

  assign w_snap = (r_presc == '0) && (r_idx == '0);

  // Digit 0's slot shows the frame being captured on that same edge.
  assign w_digits = w_snap ? digits_in : r_sh_digits;
  assign w_dp_req = w_snap ? dp_in     : r_sh_dp;
  assign w_bcd    = w_snap ? mode_bcd  : r_sh_bcd;
  assign w_blz    = w_snap ? blank_lz  : r_sh_blz;

  // A digit is blanked only while it and everything above it are zero without dp.
  always_comb begin
    w_run_zero   = w_blz;
    w_blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_run_zero      = w_run_zero && (w_digits[4*k +: 4] == 4'd0) && !w_dp_req[k];
      w_blank_mask[k] = w_run_zero;
    end
  end

  assign w_value = w_digits[{r_idx, 2'b00} +: 4];

  ssd_glyph_decoder u_glyph (
    .i_value    (w_value),
    .i_mode_bcd (w_bcd),
    .o_glyph    (w_glyph)
  );

  assign w_blank  = w_blank_mask[r_idx];
  assign w_pwm    = r_presc[BRIGHT_BITS-1:0];
  assign w_lit    = (r_presc != '0) && ((&brightness) || (w_pwm < brightness));
  assign w_onehot = NUM_DIGITS'(1) << r_idx;
  assign w_an     = (w_lit && !w_blank) ? w_onehot : '0;
  assign w_seg    = w_blank ? SEG_OFF : w_glyph;
  assign w_dp     = !w_blank && w_dp_req[r_idx];

  always_comb begin
    w_an_pin  = '0;
    w_seg_pin = '0;
    for (int k = 0; k < NUM_DIGITS; k++) w_an_pin[k] = drive_level(w_an[k], AL);
    for (int k = 0; k < 7; k++) w_seg_pin[k] = drive_level(w_seg[k], AL);
    w_dp_pin = drive_level(w_dp, AL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRE_LAST) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      r_sh_bcd    <= 1'b0;
      r_sh_blz    <= 1'b0;
    end else if (w_snap) begin
      r_sh_digits <= digits_in;
      r_sh_dp     <= dp_in;
      r_sh_bcd    <= mode_bcd;
      r_sh_blz    <= blank_lz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= {NUM_DIGITS{AL}};
      seg        <= {7{AL}};
      dp         <= AL;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_an_pin;
      seg        <= w_seg_pin;
      dp         <= w_dp_pin;
      digit_sel  <= r_idx;
      frame_tick <= w_snap;
    end
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: two instances (active-high and active-low pins)
// checked every cycle against a frame/slot arithmetic model, plus pinned literals.
module tb_ssd_scan_controller;

  localparam int N = 4;
  localparam int R = 16;
  localparam int BB = 4;
  localparam logic [16*7-1:0] GLYPHS = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        mode_bcd;
  logic        blank_lz;
  logic [3:0]  brightness;

  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [1:0] sel0, sel1;
  logic       tick0, tick1;

  int n_cmp = 0;
  int n_bad = 0;
  int ec;

  always #5 clk = ~clk;

  ssd_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BRIGHT_BITS(BB), .ACTIVE_LOW(0)) u_dut0 (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .mode_bcd(mode_bcd),
    .blank_lz(blank_lz), .brightness(brightness), .an(an0), .seg(seg0), .dp(dp0),
    .digit_sel(sel0), .frame_tick(tick0));

  ssd_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BRIGHT_BITS(BB), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .mode_bcd(mode_bcd),
    .blank_lz(blank_lz), .brightness(brightness), .an(an1), .seg(seg1), .dp(dp1),
    .digit_sel(sel1), .frame_tick(tick1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge j after reset release sits at slot position j%R of digit (j/R)%N.
  int         j;
  int         p_m, d_m;
  logic       blank_m;
  logic [3:0] f_dig [N];
  logic [3:0] f_dp;
  logic       f_bcd, f_blz;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [1:0] e_sel;
  logic       e_tick;

  always @(posedge clk) begin
    if (reset) begin
      j = 0;
      e_an = '0; e_seg = '0; e_dp = 1'b0; e_sel = '0; e_tick = 1'b0;
    end else begin
      p_m = j % R;
      d_m = (j / R) % N;
      e_tick = ((j % (R * N)) == 0);
      if (e_tick) begin
        for (int k = 0; k < N; k++) f_dig[k] = digits_in[4*k +: 4];
        f_dp  = dp_in;
        f_bcd = mode_bcd;
        f_blz = blank_lz;
      end
      blank_m = f_blz && (d_m > 0);
      for (int k = 0; k < N; k++)
        if (k >= d_m && (f_dig[k] != 4'd0 || f_dp[k])) blank_m = 1'b0;
      e_sel = 2'(d_m);
      if (blank_m) begin
        e_an = '0; e_seg = '0; e_dp = 1'b0;
      end else begin
        e_seg = (f_bcd && f_dig[d_m] > 4'd9) ? 7'h40 : GLYPHS[f_dig[d_m]*7 +: 7];
        e_dp  = f_dp[d_m];
        e_an  = (p_m != 0 && (brightness == 4'hF || (p_m % 16) < brightness)) ? 4'(1 << d_m) : 4'h0;
      end
      j++;
    end
  end

  logic [14:0] exp0, exp1;
  always @(negedge clk) begin
    if (reset) begin
      exp0 = '0;
      exp1 = {4'hF, 7'h7F, 1'b1, 2'b00, 1'b0};
    end else begin
      exp0 = {e_an, e_seg, e_dp, e_sel, e_tick};
      exp1 = {~e_an, ~e_seg, ~e_dp, e_sel, e_tick};
    end
    check("cycle_hi", {an0, seg0, dp0, sel0, tick0}, exp0);
    check("cycle_lo", {an1, seg1, dp1, sel1, tick1}, exp1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      ec++;
    end
  endtask

  task automatic goto_edge(input int t);
    while (ec < t) step(1);
  endtask

  initial begin
    digits_in = 16'h1234; dp_in = 4'h0; mode_bcd = 1'b0; blank_lz = 1'b0; brightness = 4'hF;
    ec = 0;
    step(3);
    check("rst_an", an0, 4'h0);
    check("rst_seg", seg0, 7'h00);
    check("rst_an_al", an1, 4'hF);
    check("rst_seg_al", seg1, 7'h7F);
    check("rst_dp_al", dp1, 1'b1);
    reset = 1'b0; ec = -1;

    // scan order, dead time, polarity
    step(1);
    check("tick_first", tick0, 1'b1);
    check("sel_d0", sel0, 2'd0);
    check("seg_d0_4", seg0, 7'h66);
    check("an_dead0", an0, 4'h0);
    check("an_dead0_al", an1, 4'hF);
    goto_edge(1);
    check("an_d0", an0, 4'h1);
    check("tick_once", tick0, 1'b0);
    check("an_d0_al", an1, 4'hE);
    check("seg_d0_al", seg1, 7'h19);
    goto_edge(16);
    check("sel_d1", sel0, 2'd1);
    check("seg_d1_3", seg0, 7'h4F);
    check("an_dead1", an0, 4'h0);
    goto_edge(17);
    check("an_d1", an0, 4'h2);
    goto_edge(48);
    check("seg_d3_1", seg0, 7'h06);

    // BCD then hex glyphs
    goto_edge(63);
    digits_in = 16'hA5F0; mode_bcd = 1'b1;
    goto_edge(64);
    check("tick_period", tick0, 1'b1);
    check("bcd_d0", seg0, 7'h3F);
    goto_edge(80);  check("bcd_d1_dash", seg0, 7'h40);
    goto_edge(96);  check("bcd_d2_5", seg0, 7'h6D);
    goto_edge(112); check("bcd_d3_dash", seg0, 7'h40);
    goto_edge(127); mode_bcd = 1'b0;
    goto_edge(144); check("hex_d1_F", seg0, 7'h71);
    goto_edge(176); check("hex_d3_A", seg0, 7'h77);

    // leading-zero blanking
    goto_edge(191); digits_in = 16'h0070; blank_lz = 1'b1;
    goto_edge(192); check("lz_d0", seg0, 7'h3F);
    goto_edge(208); check("lz_d1", seg0, 7'h07);
    goto_edge(224); check("lz_d2_seg", seg0, 7'h00);
    goto_edge(225); check("lz_d2_an", an0, 4'h0);
    goto_edge(240); check("lz_d3_seg", seg0, 7'h00);
    goto_edge(241); check("lz_d3_an_al", an1, 4'hF);
    goto_edge(255); dp_in = 4'b0100;
    goto_edge(288); check("lzdp_d2_seg", seg0, 7'h3F); check("lzdp_d2_dp", dp0, 1'b1);
    goto_edge(289); check("lzdp_d2_an", an0, 4'h4);
    goto_edge(304); check("lzdp_d3_seg", seg0, 7'h00); check("lzdp_d3_dp", dp0, 1'b0);

    // snapshot coherence
    goto_edge(319); digits_in = 16'h1111; dp_in = 4'h0; blank_lz = 1'b0;
    goto_edge(355); digits_in = 16'h2222;
    goto_edge(356); check("coh_d2", seg0, 7'h06);
    goto_edge(368); check("coh_d3", seg0, 7'h06);
    goto_edge(384); check("coh_tick", tick0, 1'b1); check("coh_new_d0", seg0, 7'h5B);

    // brightness and asynchronous reset
    goto_edge(399); brightness = 4'h4;
    goto_edge(401); check("pwm_on1", an0, 4'h2);
    goto_edge(403); check("pwm_on3", an0, 4'h2);
    goto_edge(404); check("pwm_off4", an0, 4'h0);
    brightness = 4'hF;
    goto_edge(410); check("pre_rst_an", an0, 4'h2);
    reset = 1'b1;
    #1;
    check("async_rst_an", an0, 4'h0);
    check("async_rst_an_al", an1, 4'hF);
    step(2);
    reset = 1'b0; ec = -1;
    step(1);
    check("restart_sel", sel0, 2'd0);
    check("restart_tick", tick0, 1'b1);
    check("restart_seg", seg0, 7'h5B);

    // randomized phase, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < N; k++)
          digits_in[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        mode_bcd = 1'($urandom_range(0, 1));
        blank_lz = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       brightness = 4'h0;
          1:       brightness = 4'hF;
          default: brightness = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        step(2);
        reset = 1'b0; ec = -1;
      end
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
